eco32_ethernet_ptr_mc: RTL and testbench

Multi-channel pointer/descriptor store for the Ethernet path: one shared simple-dual-port RAM (1 read, 1 write per cycle) statically partitioned into `CHANNELS` equal regions, one per client. Each channel issues read, write or fetch-and-increment operations through a one-deep request slot. A round-robin arbiter grants at most one operation per cycle. Read results return on a per-channel registered strobe/data pair. It generalises the fixed two-port split store to N channels and adds atomic pointer increment.

---
 rtl/eco32_ethernet_ptr_mc.sv | 229 ++++++++++++++++++++++
 tb/tb_eco32_ethernet_ptr_mc.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/eco32_ethernet_ptr_mc.sv
// eco32_ethernet_ptr_mc
// Multi-channel pointer/descriptor store. A single simple-dual-port RAM is
// split into CHANNELS equal regions, one per client. Each channel posts a
// read, write or fetch-and-increment into a one-deep slot. A round-robin
// arbiter grants at most one slot per cycle. Read results come back on a
// per-channel registered strobe/data pair.
//
// Ports
//   clk        : clock
//   rst        : asynchronous active-high reset
//   ch_i_stb   : [CHANNELS]            request strobe per channel
//   ch_i_op    : [2*CHANNELS]          00 read, 01 write, 10 fetch-inc, 11 read
//   ch_i_addr  : [REGION_AW*CHANNELS]  word address inside the channel region
//   ch_i_data  : [DATA_WIDTH*CHANNELS] write data
//   ch_o_rdy   : [CHANNELS]            request slot empty
//   ch_o_stb   : [CHANNELS]            result valid, one-cycle pulse
//   ch_o_data  : [DATA_WIDTH*CHANNELS] result data, held between strobes
module eco32_ethernet_ptr_mc #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 36,
  parameter int REGION_AW  = 7
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS-1:0]            ch_i_stb,
  input  logic [2*CHANNELS-1:0]          ch_i_op,
  input  logic [REGION_AW*CHANNELS-1:0]  ch_i_addr,
  input  logic [DATA_WIDTH*CHANNELS-1:0] ch_i_data,
  output logic [CHANNELS-1:0]            ch_o_rdy,
  output logic [CHANNELS-1:0]            ch_o_stb,
  output logic [DATA_WIDTH*CHANNELS-1:0] ch_o_data
);

  localparam int CW    = $clog2(CHANNELS);
  localparam int PAW   = CW + REGION_AW;
  localparam int DEPTH = CHANNELS << REGION_AW;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FINC  = 2'b10;

  // Unpacked views of the flattened input buses
  logic [1:0]            in_op   [CHANNELS];
  logic [REGION_AW-1:0]  in_addr [CHANNELS];
  logic [DATA_WIDTH-1:0] in_data [CHANNELS];

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_unpack
      assign in_op[gi]   = ch_i_op[2*gi +: 2];
      assign in_addr[gi] = ch_i_addr[REGION_AW*gi +: REGION_AW];
      assign in_data[gi] = ch_i_data[DATA_WIDTH*gi +: DATA_WIDTH];
    end
  endgenerate

  // Request slots; rdy_q=1 means the slot is empty
  logic [CHANNELS-1:0]   rdy_q, rdy_d;
  logic [1:0]            slot_op_q   [CHANNELS];
  logic [1:0]            slot_op_d   [CHANNELS];
  logic [REGION_AW-1:0]  slot_addr_q [CHANNELS];
  logic [REGION_AW-1:0]  slot_addr_d [CHANNELS];
  logic [DATA_WIDTH-1:0] slot_data_q [CHANNELS];
  logic [DATA_WIDTH-1:0] slot_data_d [CHANNELS];

  // Arbiter state
  logic [CW-1:0] last_q, last_d;
  logic [1:0]    bub_q, bub_d;   // grant-free edges still owed to a fetch-inc
  logic          grant_vld;
  logic [CW-1:0] grant_ch;

  // Read pipeline: s1 = address registered, s2 = RAM word registered
  logic           s1_vld_q, s1_vld_d, s1_fi_q, s1_fi_d;
  logic [CW-1:0]  s1_ch_q, s1_ch_d;
  logic [PAW-1:0] s1_addr_q, s1_addr_d;
  logic           s2_vld_q, s2_fi_q;
  logic [CW-1:0]  s2_ch_q;
  logic [PAW-1:0] s2_addr_q;

  // Outputs
  logic [CHANNELS-1:0]            stb_q, stb_d;
  logic [DATA_WIDTH*CHANNELS-1:0] data_q, data_d;

  // RAM
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  mem_we;
  logic [PAW-1:0]        mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;

  // Grant decode
  logic [1:0]     g_op;
  logic           g_is_wr, g_is_fi, g_is_rd;
  logic [PAW-1:0] g_paddr;
  logic           wb_en;

  // Round-robin search from last+1 with wrap; the CW-bit sum wraps for free
  // because CHANNELS is a power of two. No grant while a bubble is owed.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    if (bub_q == 2'd0) begin
      for (int i = 1; i <= CHANNELS; i++) begin
        if (!grant_vld && !rdy_q[last_q + CW'(i)]) begin
          grant_vld = 1'b1;
          grant_ch  = last_q + CW'(i);
        end
      end
    end
  end

  always_comb begin
    g_op    = slot_op_q[grant_ch];
    g_is_wr = grant_vld && (g_op == OP_WRITE);
    g_is_fi = grant_vld && (g_op == OP_FINC);
    g_is_rd = grant_vld && !g_is_wr;       // read, fetch-inc and reserved op
    g_paddr = {grant_ch, slot_addr_q[grant_ch]};
  end

  always_comb begin
    last_d = grant_vld ? grant_ch : last_q;
    if (g_is_fi) begin
      bub_d = 2'd2;
    end else if (bub_q != 2'd0) begin
      bub_d = bub_q - 2'd1;
    end else begin
      bub_d = 2'd0;
    end
  end

  // Slot accept/clear. Accept needs an empty slot and grant needs a full one,
  // so the two never hit the same slot on the same edge.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      rdy_d[k]       = rdy_q[k];
      slot_op_d[k]   = slot_op_q[k];
      slot_addr_d[k] = slot_addr_q[k];
      slot_data_d[k] = slot_data_q[k];
      if (rdy_q[k] && ch_i_stb[k]) begin
        rdy_d[k]       = 1'b0;
        slot_op_d[k]   = in_op[k];
        slot_addr_d[k] = in_addr[k];
        slot_data_d[k] = in_data[k];
      end else if (grant_vld && (grant_ch == CW'(k))) begin
        rdy_d[k] = 1'b1;
      end
    end
  end

  always_comb begin
    s1_vld_d  = g_is_rd;
    s1_fi_d   = g_is_fi;
    s1_ch_d   = grant_ch;
    s1_addr_d = g_paddr;
  end

  always_comb begin
    stb_d  = '0;
    data_d = data_q;
    for (int k = 0; k < CHANNELS; k++) begin
      if (s2_vld_q && (s2_ch_q == CW'(k))) begin
        stb_d[k]                         = 1'b1;
        data_d[DATA_WIDTH*k +: DATA_WIDTH] = ram_q;
      end
    end
  end

  // The fetch-inc writeback shares the write port with granted writes; the
  // two-edge bubble guarantees no grant coincides with it.
  always_comb begin
    wb_en  = s2_vld_q && s2_fi_q;
    mem_we = wb_en || g_is_wr;
    mem_wa = wb_en ? s2_addr_q : g_paddr;
    mem_wd = wb_en ? (ram_q + DATA_WIDTH'(1)) : slot_data_q[grant_ch];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q     <= '1;
      last_q    <= CW'(CHANNELS - 1);
      bub_q     <= 2'd0;
      s1_vld_q  <= 1'b0;
      s1_fi_q   <= 1'b0;
      s1_ch_q   <= '0;
      s1_addr_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_fi_q   <= 1'b0;
      s2_ch_q   <= '0;
      s2_addr_q <= '0;
      stb_q     <= '0;
      data_q    <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        slot_op_q[k]   <= '0;
        slot_addr_q[k] <= '0;
        slot_data_q[k] <= '0;
      end
    end else begin
      rdy_q     <= rdy_d;
      last_q    <= last_d;
      bub_q     <= bub_d;
      s1_vld_q  <= s1_vld_d;
      s1_fi_q   <= s1_fi_d;
      s1_ch_q   <= s1_ch_d;
      s1_addr_q <= s1_addr_d;
      s2_vld_q  <= s1_vld_q;
      s2_fi_q   <= s1_fi_q;
      s2_ch_q   <= s1_ch_q;
      s2_addr_q <= s1_addr_q;
      stb_q     <= stb_d;
      data_q    <= data_d;
      for (int k = 0; k < CHANNELS; k++) begin
        slot_op_q[k]   <= slot_op_d[k];
        slot_addr_q[k] <= slot_addr_d[k];
        slot_data_q[k] <= slot_data_d[k];
      end
    end
  end

  // Block RAM: contents are never reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
    ram_q <= mem[s1_addr_q];
  end

  assign ch_o_rdy  = rdy_q;
  assign ch_o_stb  = stb_q;
  assign ch_o_data = data_q;

endmodule

// File: tb/tb_eco32_ethernet_ptr_mc.sv
module tb_eco32_ethernet_ptr_mc;

  localparam int CH = 4;
  localparam int DW = 36;
  localparam int AW = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CH-1:0]     ch_i_stb  = '0;
  logic [2*CH-1:0]   ch_i_op   = '0;
  logic [AW*CH-1:0]  ch_i_addr = '0;
  logic [DW*CH-1:0]  ch_i_data = '0;
  logic [CH-1:0]     ch_o_rdy;
  logic [CH-1:0]     ch_o_stb;
  logic [DW*CH-1:0]  ch_o_data;

  eco32_ethernet_ptr_mc #(
    .CHANNELS  (CH),
    .DATA_WIDTH(DW),
    .REGION_AW (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ch_i_stb (ch_i_stb),
    .ch_i_op  (ch_i_op),
    .ch_i_addr(ch_i_addr),
    .ch_i_data(ch_i_data),
    .ch_o_rdy (ch_o_rdy),
    .ch_o_stb (ch_o_stb),
    .ch_o_data(ch_o_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    ch;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [CH][1 << AW];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            acc_cyc [CH];
  int            stb_cyc [CH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Result monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < CH; k++) begin
        if (ch_o_stb[k]) begin
          stb_cyc[k] = cyc;
          $display("result ch%0d data=0x%0h cyc=%0d", k, ch_o_data[DW*k +: DW], cyc);
          if (sb.size() == 0) begin
            check("spurious_stb", 64'(k + 1), 64'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("res_ch", 64'(k), 64'(e.ch));
            check("res_data", 64'(ch_o_data[DW*k +: DW]), 64'(e.data));
          end
        end
      end
    end
  end

  task automatic issue(input int ch, input logic [1:0] op, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data);
    int n;
    n = 0;
    @(negedge clk);
    while (!ch_o_rdy[ch] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("rdy_timeout", 64'd0, 64'd1);
    ch_i_stb[ch]            = 1'b1;
    ch_i_op[2*ch +: 2]      = op;
    ch_i_addr[AW*ch +: AW]  = addr;
    ch_i_data[DW*ch +: DW]  = data;
    @(posedge clk);
    #1;
    acc_cyc[ch]  = cyc;
    ch_i_stb[ch] = 1'b0;
  endtask

  task automatic push_exp(input int ch, input logic [DW-1:0] d);
    exp_t e;
    e.ch   = 2'(ch);
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic do_write(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
    model[ch][a] = d;
    issue(ch, 2'b01, a, d);
  endtask

  task automatic do_read(input int ch, input logic [AW-1:0] a, input logic [1:0] op);
    push_exp(ch, model[ch][a]);
    issue(ch, op, a, '0);
  endtask

  task automatic do_finc(input int ch, input logic [AW-1:0] a);
    push_exp(ch, model[ch][a]);
    model[ch][a] = model[ch][a] + DW'(1);
    issue(ch, 2'b10, a, '0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || ch_o_rdy != 4'hF) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("drain_timeout", 64'd1, 64'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    check("global_timeout", 64'd1, 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rdy", 64'(ch_o_rdy), 64'hF);
    check("rst_stb", 64'(ch_o_stb), 64'h0);
    check("rst_data", 64'(|ch_o_data), 64'h0);

    // Write then read on ch0, latency from read accept to strobe
    do_write(0, 7'd5, 36'h1_2345_6789);
    do_read(0, 7'd5, 2'b00);
    wait_idle();
    check("read_latency", 64'(stb_cyc[0] - acc_cyc[0]), 64'd3);

    // Region isolation, reserved op executes as read
    do_write(1, 7'd5, 36'hAA);
    do_write(2, 7'd5, 36'hBB);
    do_read(1, 7'd5, 2'b00);
    do_read(2, 7'd5, 2'b11);
    wait_idle();

    // Simultaneous reads after reset: order 0,1,2,3 twice
    do_write(3, 7'd5, 36'hCC);
    wait_idle();
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      @(negedge clk);
      for (int k = 0; k < CH; k++) begin
        push_exp(k, model[k][5]);
        ch_i_stb[k]           = 1'b1;
        ch_i_op[2*k +: 2]     = 2'b00;
        ch_i_addr[AW*k +: AW] = 7'd5;
      end
      @(posedge clk);
      #1;
      ch_i_stb = '0;
      wait_idle();
      for (int k = 1; k < CH; k++) begin
        check("rr_consecutive", 64'(stb_cyc[k] - stb_cyc[0]), 64'(k));
      end
    end

    // Fetch-inc wrap on ch3 with ch0 read pending behind the bubble
    do_write(3, 7'd0, 36'hF_FFFF_FFFF);
    wait_idle();
    do_finc(3, 7'd0);
    do_read(0, 7'd5, 2'b00);
    wait_idle();
    check("finc_bubble", 64'(stb_cyc[0] - stb_cyc[3]), 64'd3);
    do_read(3, 7'd0, 2'b00);
    wait_idle();
    check("finc_wrap_model", 64'(model[3][0]), 64'd0);

    // Back-to-back fetch-inc on ch1 addr 7
    do_write(1, 7'd7, 36'd10);
    for (int i = 0; i < 4; i++) do_finc(1, 7'd7);
    do_read(1, 7'd7, 2'b00);
    wait_idle();

    // Reset one cycle after a fetch-inc grant: word stays unchanged
    do_write(2, 7'd3, 36'h20);
    wait_idle();
    issue(2, 2'b10, 7'd3, '0);
    @(posedge clk);          // grant edge
    @(posedge clk);          // grant + 1
    #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_rdy", 64'(ch_o_rdy), 64'hF);
    check("midrst_stb", 64'(ch_o_stb), 64'h0);
    repeat (4) @(negedge clk);
    do_read(2, 7'd3, 2'b00);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
